// File: rtl/ternary_pkg.sv
// Shared ternary types for the SRAM wrapper and its request-side controller.
//   trit_t              2-bit trit encoding: 00 = 0, 01 = +1, 10 = -1, 11 = invalid
//   T_*                 named trit values
//   tsram_ctrl_state_e  controller FSM states
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS     = 2'b01;
    localparam trit_t T_NEG     = 2'b10;
    localparam trit_t T_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } tsram_ctrl_state_e;

endpackage

// File: rtl/ternary_resp_fifo.sv
// Two-entry response buffer holding read beats as packed {data, last, err}.
// Ports:
//   clk, rst    clock; synchronous active-high flush
//   push, din   write an entry
//   pop         consume the head entry (ignored when empty)
//   dout        head entry (stale when count == 0; caller qualifies)
//   count       occupancy, 0..2
module ternary_resp_fifo #(
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

    // The controller throttles issue so a push never lands on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/ternary_sram_ctrl.sv
// Request-side initiator for the ternary SRAM wrapper. Accepts single or burst
// read/write requests over valid/ready, drives the wrapper port, absorbs the
// wrapper's 1-cycle read latency and returns read beats through a 2-entry buffer.
// Optional build macro: TSRAM_ERR_CHECK_EN -- flags read beats containing an
// invalid trit on rd_err; when undefined rd_err is always 0.
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   req_valid/ready/we/addr/len     burst request (len = beats - 1)
//   wr_valid/ready/data             write beat stream
//   rd_valid/ready/data/last/err    read beat stream
//   busy                            FSM active or response buffer non-empty
//   sram_addr/we/re/ce/wdata        wrapper command port
//   sram_rdata                      wrapper read data, valid the cycle after sram_re
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// WRITE | forwarding write beats to the wrapper
// READ  | issuing reads while the buffer has room
// DRAIN | all reads issued, waiting for buffer and pipeline to empty
module ternary_sram_ctrl
    import ternary_pkg::*;
#(
    parameter  int TRIT_WIDTH = 27,
    parameter  int ADDR_BITS  = 8,
    parameter  int DEPTH      = 256,
    parameter  int MAX_BURST  = 16,
    localparam int LEN_BITS   = $clog2(MAX_BURST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_BITS-1:0]     req_addr,
    input  logic [LEN_BITS-1:0]      req_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  trit_t [TRIT_WIDTH-1:0]   wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output trit_t [TRIT_WIDTH-1:0]   rd_data,
    output logic                     rd_last,
    output logic                     rd_err,
    output logic                     busy,
    output logic [ADDR_BITS-1:0]     sram_addr,
    output logic                     sram_we,
    output logic                     sram_re,
    output logic                     sram_ce,
    output trit_t [TRIT_WIDTH-1:0]   sram_wdata,
    input  trit_t [TRIT_WIDTH-1:0]   sram_rdata
);

    localparam int CNT_W  = LEN_BITS + 1;
    localparam int FIFO_W = 2 * TRIT_WIDTH + 2;

    tsram_ctrl_state_e         state, state_nxt;
    logic [ADDR_BITS-1:0]      addr_q, addr_nxt;
    logic [CNT_W-1:0]          cnt_q, cnt_nxt;
    logic                      inflight_q, inflight_last_q;
    logic                      issue, last_beat, pop, cap_err, head_valid;
    logic [1:0]                fifo_count;
    logic [2:0]                occupancy;
    logic [FIFO_W-1:0]         fifo_din, fifo_dout;
    trit_t [TRIT_WIDTH-1:0]    head_data;
    logic                      head_last, head_err;

    logic                      req_ready_i, wr_ready_i, sram_we_i, sram_re_i;
    logic [ADDR_BITS-1:0]      sram_addr_i;
    trit_t [TRIT_WIDTH-1:0]    sram_wdata_i;

    function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
        return (a == ADDR_BITS'(DEPTH - 1)) ? '0 : a + ADDR_BITS'(1);
    endfunction

    assign head_valid = (fifo_count != 2'd0);
    assign pop        = head_valid && rd_ready;
    assign last_beat  = (cnt_q == CNT_W'(1));
    // Slots already spoken for next cycle, crediting a pop happening now.
    assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        cnt_nxt      = cnt_q;
        issue        = 1'b0;
        req_ready_i  = 1'b0;
        wr_ready_i   = 1'b0;
        sram_we_i    = 1'b0;
        sram_re_i    = 1'b0;
        sram_addr_i  = '0;
        sram_wdata_i = '0;
        case (state)
            IDLE: begin
                req_ready_i = 1'b1;
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    cnt_nxt   = CNT_W'(req_len) + CNT_W'(1);
                    state_nxt = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_i  = 1'b1;
                sram_addr_i = addr_q;
                if (wr_valid) begin
                    sram_we_i    = 1'b1;
                    sram_wdata_i = wr_data;
                    addr_nxt     = addr_inc(addr_q);
                    cnt_nxt      = cnt_q - CNT_W'(1);
                    if (last_beat) state_nxt = IDLE;
                end
            end
            READ: begin
                sram_addr_i = addr_q;
                if (occupancy < 3'd2) begin
                    issue     = 1'b1;
                    sram_re_i = 1'b1;
                    addr_nxt  = addr_inc(addr_q);
                    cnt_nxt   = cnt_q - CNT_W'(1);
                    if (last_beat) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!head_valid && !inflight_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state           <= state_nxt;
            addr_q          <= addr_nxt;
            cnt_q           <= cnt_nxt;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_beat;
        end
    end

`ifdef TSRAM_ERR_CHECK_EN
    always_comb begin
        cap_err = 1'b0;
        for (int i = 0; i < TRIT_WIDTH; i++) begin
            if (sram_rdata[i] == T_INVALID) cap_err = 1'b1;
        end
    end
`else
    assign cap_err = 1'b0;
`endif

    assign fifo_din = {sram_rdata, inflight_last_q, cap_err};

    ternary_resp_fifo #(.WIDTH(FIFO_W)) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign {head_data, head_last, head_err} = fifo_dout;

    // Outputs are forced low while rst is high, whatever state the FSM was in.
    assign req_ready  = !rst && req_ready_i;
    assign wr_ready   = !rst && wr_ready_i;
    assign sram_we    = !rst && sram_we_i;
    assign sram_re    = !rst && sram_re_i;
    assign sram_ce    = sram_we || sram_re;
    assign sram_addr  = rst ? '0 : sram_addr_i;
    assign sram_wdata = rst ? '0 : sram_wdata_i;
    assign rd_valid   = !rst && head_valid;
    assign rd_data    = rd_valid ? head_data : '0;
    assign rd_last    = rd_valid && head_last;
    assign rd_err     = rd_valid && head_err;
    assign busy       = !rst && ((state != IDLE) || head_valid);

endmodule

// File: tb/tb_ternary_sram_ctrl.sv
module tb_ternary_sram_ctrl;
    import ternary_pkg::*;

    localparam int TW = 27;
    typedef trit_t [TW-1:0] word_t;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic        wr_valid, wr_ready;
    word_t       wr_data;
    logic        rd_valid, rd_ready, rd_last, rd_err, busy;
    word_t       rd_data;
    logic [7:0]  sram_addr;
    logic        sram_we, sram_re, sram_ce;
    word_t       sram_wdata, sram_rdata;

    ternary_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .rd_err(rd_err), .busy(busy),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re),
        .sram_ce(sram_ce), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper model: registered read, optional trit[5] corruption at one address.
    word_t      mem [256];
    word_t      shadow [256];
    logic       inj_en;
    logic [7:0] inj_addr;
    always @(posedge clk) begin
        if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_ce && sram_re) begin
            sram_rdata <= mem[sram_addr];
            if (inj_en && sram_addr == inj_addr) sram_rdata[5] <= T_INVALID;
        end
    end

    int errs, checks;
    word_t wbuf [16];
    logic [5:0] pat;

    typedef struct { logic [7:0] addr; word_t data; } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t fill(input trit_t t);
        word_t w;
        for (int i = 0; i < TW; i++) w[i] = t;
        return w;
    endfunction

    function automatic word_t mixw(input int s);
        word_t w;
        for (int i = 0; i < TW; i++) begin
            case ((i + s) % 3)
                0:       w[i] = T_ZERO;
                1:       w[i] = T_POS;
                default: w[i] = T_NEG;
            endcase
        end
        return w;
    endfunction

    function automatic word_t exp_word(input logic [7:0] a);
        word_t w;
        w = shadow[a];
        if (inj_en && a == inj_addr) w[5] = T_INVALID;
        return w;
    endfunction

    function automatic logic exp_err(input word_t w);
        logic e;
        e = 1'b0;
`ifdef TSRAM_ERR_CHECK_EN
        for (int i = 0; i < TW; i++) if (w[i] == T_INVALID) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic all_out_or();
        return |{req_ready, wr_ready, rd_valid, rd_data, rd_last, rd_err, busy,
                 sram_addr, sram_we, sram_re, sram_ce, sram_wdata};
    endfunction

    task automatic send_req(input logic we, input logic [7:0] addr, input logic [3:0] len);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("req_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [3:0] len, input int gap_at);
        logic [7:0] a;
        send_req(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk); wr_valid = 1'b0; #1;
                    chk("gap_we", sram_we, 0);
                    chk("gap_addr_hold", sram_addr, a);
                end
            end
            @(negedge clk);
            wr_valid = 1'b1; wr_data = wbuf[i];
            #1;
            chk("wr_ready", wr_ready, 1);
            chk("wr_we_ce", {sram_we, sram_ce, sram_re}, 3'b110);
            chk("wr_addr", sram_addr, a);
            chk("wr_wdata", sram_wdata, wbuf[i]);
            shadow[a] = wbuf[i];
            @(posedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0; wr_data = '0;
        #1;
        chk("wr_done_idle", req_ready, 1);
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len, input bit use_pat);
        int beat, cyc, first, lastc;
        logic [7:0] a;
        word_t w;
        beat = 0; cyc = 1; first = -1; lastc = 0;
        send_req(1'b0, addr, len);
        while (beat <= int'(len) && cyc < 200) begin
            @(negedge clk);
            rd_ready = use_pat ? pat[cyc % 6] : 1'b1;
            #1;
            if (rd_valid && first < 0) first = cyc;
            if (rd_valid && rd_ready) begin
                a = addr + 8'(beat);
                w = exp_word(a);
                chk("rd_data", rd_data, w);
                chk("rd_last", rd_last, (beat == int'(len)));
                chk("rd_err", rd_err, exp_err(w));
                beat++;
                lastc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rd_beat_count", beat, int'(len) + 1);
        chk("rd_first_latency", first, 3);
        if (!use_pat) chk("rd_rate", lastc - first + 1, int'(len) + 1);
        rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rd_done_idle", {req_ready, busy, rd_valid}, 3'b100);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errs = 0; checks = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        inj_en = 1'b0; inj_addr = '0; pat = 6'b011001;

        vecs[0] = '{addr: 8'd0,   data: fill(T_ZERO)};
        vecs[1] = '{addr: 8'd255, data: fill(T_POS)};
        vecs[2] = '{addr: 8'd128, data: fill(T_NEG)};
        vecs[3] = '{addr: 8'd77,  data: mixw(1)};
        vecs[3].data[5] = T_INVALID;

        repeat (2) begin
            @(negedge clk); #1;
            chk("reset_outs_zero", all_out_or(), 0);
        end
        @(negedge clk); rst = 1'b0; #1;
        chk("post_reset_ready_busy", {req_ready, busy}, 2'b10);

        // Table: single-beat write then read-back at each address.
        for (int v = 0; v < 4; v++) begin
            wbuf[0] = vecs[v].data;
            write_burst(vecs[v].addr, 4'd0, -1);
            read_burst(vecs[v].addr, 4'd0, 1'b0);
        end

        // 4-beat burst at 10: +1 / -1 / 0 / +13.
        wbuf[0] = fill(T_POS);
        wbuf[1] = fill(T_NEG);
        wbuf[2] = fill(T_ZERO);
        wbuf[3] = fill(T_ZERO);
        wbuf[3][0] = T_POS; wbuf[3][1] = T_POS; wbuf[3][2] = T_POS;
        write_burst(8'd10, 4'd3, -1);
        read_burst(8'd10, 4'd3, 1'b0);

        // Wrap across the top of the address space.
        for (int i = 0; i < 4; i++) wbuf[i] = mixw(i + 2);
        write_burst(8'd254, 4'd3, -1);
        read_burst(8'd254, 4'd3, 1'b0);

        // 8 beats: backpressure pattern, then full rate.
        for (int i = 0; i < 8; i++) wbuf[i] = mixw(i);
        wbuf[7][0] = T_NEG;
        write_burst(8'd100, 4'd7, -1);
        read_burst(8'd100, 4'd7, 1'b1);
        read_burst(8'd100, 4'd7, 1'b0);

        // Write stalls three cycles before beat 2.
        for (int i = 0; i < 4; i++) wbuf[i] = mixw(2 * i + 1);
        write_burst(8'd200, 4'd3, 2);
        read_burst(8'd200, 4'd3, 1'b0);

        // Reset in the cycle the second read beat is issued.
        send_req(1'b0, 8'd10, 4'd7);
        @(negedge clk); #1;
        chk("rst_test_issue1", {sram_re, sram_ce, sram_addr}, {2'b11, 8'd10});
        @(negedge clk); #1;
        chk("rst_test_issue2", {sram_re, sram_ce, sram_addr}, {2'b11, 8'd11});
        rst = 1'b1; #1;
        chk("rst_mid_outs_zero", all_out_or(), 0);
        @(negedge clk); #1;
        chk("rst_next_outs_zero", all_out_or(), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_release_state", {req_ready, busy, rd_valid}, 3'b100);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_no_stale_valid", rd_valid, 0);
        end
        read_burst(8'd10, 4'd3, 1'b0);

        // Invalid trit injected by the wrapper at address 40.
        wbuf[0] = fill(T_POS); wbuf[1] = fill(T_ZERO); wbuf[2] = fill(T_NEG);
        write_burst(8'd39, 4'd2, -1);
        inj_en = 1'b1; inj_addr = 8'd40;
        read_burst(8'd39, 4'd2, 1'b0);
        inj_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ternary_sram_ctrl.md
Name: ternary_sram_ctrl

Overview:
Request-side initiator for the ternary SRAM wrapper. It accepts single or burst read/write requests from a CPU/LSU over valid/ready handshakes and drives the wrapper's ternary port (addr/we/re/ce/wdata).
- Absorbs the wrapper's 1-cycle registered read latency.
- Returns read beats through a 2-entry response buffer, so backpressure never loses data.

Parameters:
TRIT_WIDTH, 27, trits per word
ADDR_BITS, 8, SRAM word address width
DEPTH, 256, words in the SRAM; addresses wrap modulo DEPTH
MAX_BURST, 16, maximum beats per request; LEN_BITS = $clog2(MAX_BURST)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_BITS  start word address
req_len  in  LEN_BITS  beats minus 1
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted
wr_data  in  TRIT_WIDTH×trit_t  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat consumed
rd_data  out  TRIT_WIDTH×trit_t  read beat data
rd_last  out  1  final beat of the burst
rd_err  out  1  beat contains an invalid trit (see Optional Feature)
busy  out  1  state != IDLE or response buffer non-empty
sram_addr  out  ADDR_BITS  to wrapper addr
sram_we  out  1  to wrapper we
sram_re  out  1  to wrapper re
sram_ce  out  1  to wrapper ce; equals sram_we | sram_re
sram_wdata  out  TRIT_WIDTH×trit_t  to wrapper wdata_trit
sram_rdata  in  TRIT_WIDTH×trit_t  from wrapper rdata_trit; valid the cycle after sram_re

Behaviour:
- Interface: single clock clk; synchronous active-high reset rst.
- Reset: while rst=1, next state is IDLE, the response buffer is flushed and the in-flight flag is cleared. During the reset cycle and the cycle after it, all outputs are 0, including req_ready, busy and every sram_* signal. req_ready=1 from the first cycle after rst deasserts.
- Reset mid-burst: the burst is aborted and a read in flight is dropped. The next write is not completed.
- FSM states: IDLE, WRITE, READ, DRAIN.
  - IDLE: req_ready=1. On handshake, latch addr, beat count = req_len+1 and direction, then go to WRITE or READ.
  - WRITE: wr_ready=1. While wr_valid=1: sram_we=sram_ce=1, sram_wdata=wr_data (combinational), sram_addr=current addr. On each beat, addr advances and count decrements. After the final beat, go to IDLE. While wr_valid=0, sram_we=0 and addr holds.
  - READ: sram_re=sram_ce=1 when occupancy + inflight − (rd_valid&rd_ready) < 2. On each issue, addr advances and count decrements. After the last issue, go to DRAIN.
  - DRAIN: when the buffer is empty and inflight=0, go to IDLE.
- Read capture: the inflight flag is set in the cycle after issue. In that cycle sram_rdata is pushed with its last flag (set for the final issue) and its err flag.
- Latency and throughput:
  - First rd_valid occurs 3 cycles after req acceptance.
  - Sustained rate is 1 beat/cycle with rd_ready held high.
  - Writes commit 1 beat/cycle.
- Address wrap: next address = (addr == DEPTH−1) ? 0 : addr+1.
- rd_* outputs come from the buffer head. Buffer overflow is impossible by construction; an assertion checks it.
- Back-to-back requests: a new request is accepted only in IDLE. The minimum bubble between bursts is 1 cycle.
- sram_* outputs are combinational from registered state plus wr_valid, rd_ready and buffer count. They are 0 in IDLE.

Optional Feature:
TSRAM_ERR_CHECK_EN
- Defined: at capture, rd_err = OR over all trits of (trit == T_INVALID). The flag is stored in the buffer alongside the data.
- Undefined: rd_err is tied to 0 and no check logic is generated.

Decomposition:
- ternary_pkg: existing trit_t and T_INVALID, plus tsram_ctrl_state_e (IDLE/WRITE/READ/DRAIN).
- Sub-module ternary_resp_fifo: 2-entry FIFO of {data, last, err} with push/pop, count, and synchronous active-high reset flush.

Test Plan:
- Write at addr 10, req_len=3, data +1/−1/0/+13 patterns; then read at addr 10, req_len=3. Required: 4 beats match the written data in order; rd_last only on beat 4; first rd_valid 3 cycles after read acceptance.
- Write at addr 254, req_len=3. Required: sram_addr sequence 254, 255, 0, 1. Read back matches.
- Read of 8 beats with rd_ready pattern 1,0,0,1,1,0… Required: all 8 beats delivered in order, no duplicates; buffer count ≤2; with rd_ready stuck at 1, one beat per cycle.
- wr_valid low for 3 cycles mid-burst. Required: sram_we=0 and sram_addr held for those cycles; the burst completes with correct data.
- rst asserted in the cycle the 2nd read beat is issued. Required: all outputs 0 next cycle; no stale rd_valid afterwards; req_ready=1 after release; a fresh read returns correct data.
- SRAM model returns a word with trit[5]=2'b11. Required: rd_err=1 on that beat only with TSRAM_ERR_CHECK_EN defined; rd_err=0 without it.
